// File: rtl/apb_bcd_master_pkg.sv
// Shared types and constants for the APB BCD-subtractor requester.
package apb_bcd_pkg;

    localparam int BCD_W = 12;

    localparam logic [31:0] CTRL_ADDR_DEF = 32'h0;
    localparam logic [31:0] OPA_ADDR_DEF  = 32'h4;
    localparam logic [31:0] OPB_ADDR_DEF  = 32'h8;
    localparam logic [31:0] OUT_ADDR_DEF  = 32'hC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP,
        ST_ABORT
    } state_t;

    typedef enum logic [1:0] {
        X_WR_A,
        X_WR_B,
        X_WR_CTRL,
        X_RD_OUT
    } xfer_t;

    // Job-level view used by the sequencer; the transfer engine owns SETUP/ACCESS/ABORT.
    typedef enum logic [1:0] {
        J_IDLE,
        J_BUSY,
        J_RESP
    } job_t;

    function automatic xfer_t next_xfer(input xfer_t x);
        unique case (x)
            X_WR_A:    return X_WR_B;
            X_WR_B:    return X_WR_CTRL;
            X_WR_CTRL: return X_RD_OUT;
            default:   return X_RD_OUT;
        endcase
    endfunction

endpackage

// File: rtl/apb_bcd_master_if.sv
// Request/response handshake plus APB bus signals for apb_bcd_master.
interface apb_bcd_master_if;
    import apb_bcd_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [BCD_W-1:0] req_a;
    logic [BCD_W-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [BCD_W-1:0] rsp_result;
    logic             rsp_error;

    logic             PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [31:0]      PADDR;
    logic [31:0]      PWDATA;
    logic [31:0]      PRDATA;
    logic             PREADY;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready, PRDATA, PREADY,
        output req_ready, rsp_valid, rsp_result, rsp_error,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready, PRDATA, PREADY,
        input  req_ready, rsp_valid, rsp_result, rsp_error,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_xfer_fsm.sv
// Single APB transfer engine (SETUP -> ACCESS[, ABORT]); chains transfers when start meets done.
// Timeout/ABORT path built only with APB_BCD_MASTER_TIMEOUT_EN.
module apb_xfer_fsm
    import apb_bcd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic        write,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        abort,
    output logic [31:0] rdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready
);

    state_t state, state_nxt;
    logic   busy;
    logic   expired;

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

`ifdef APB_BCD_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    // Counts ACCESS cycles of the current transfer; zero in SETUP.
    always_ff @(posedge PCLK) begin
        if (PRESET || state != ST_ACCESS) wait_cnt <= '0;
        else                              wait_cnt <= wait_cnt + CW'(1);
    end

    assign expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
    assign expired = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        abort     = 1'b0;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (pready) begin
                    done      = 1'b1;
                    state_nxt = start ? ST_SETUP : ST_IDLE;
                end else if (expired) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_ABORT: begin
                abort     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign busy    = (state == ST_SETUP) || (state == ST_ACCESS);
    assign psel    = busy;
    assign penable = (state == ST_ACCESS);
    assign pwrite  = busy & write;
    assign paddr   = busy ? addr  : 32'h0;
    assign pwdata  = busy ? wdata : 32'h0;
    assign rdata   = prdata;

endmodule

// File: rtl/apb_bcd_master.sv
// Sequences WR_A, WR_B, WR_CTRL, RD_OUT for one BCD subtraction job per request.
// Optional transfer timeout: define APB_BCD_MASTER_TIMEOUT_EN.
module apb_bcd_master
    import apb_bcd_pkg::*;
#(
    parameter logic [31:0] CTRL_ADDR      = CTRL_ADDR_DEF,
    parameter logic [31:0] OPA_ADDR       = OPA_ADDR_DEF,
    parameter logic [31:0] OPB_ADDR       = OPB_ADDR_DEF,
    parameter logic [31:0] OUT_ADDR       = OUT_ADDR_DEF,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_bcd_master_if.master  bus
);

    job_t             job, job_nxt;
    xfer_t            xfer;
    logic [BCD_W-1:0] op_a, op_b;
    logic [BCD_W-1:0] res_q;
    logic             rdy_q;
    logic             accept;
    logic             x_start, x_done, x_abort, x_write;
    logic [31:0]      x_addr, x_wdata, x_rdata;
    logic             unused_rdata_hi;

    assign accept = (job == J_IDLE) && rdy_q && bus.req_valid;

    // Next transfer is launched in the same cycle the current one completes.
    assign x_start = accept || (job == J_BUSY && x_done && xfer != X_RD_OUT);

    always_comb begin
        x_addr  = OPA_ADDR;
        x_write = 1'b1;
        x_wdata = {{(32-BCD_W){1'b0}}, op_a};
        unique case (xfer)
            X_WR_A:    ;
            X_WR_B: begin
                x_addr  = OPB_ADDR;
                x_wdata = {{(32-BCD_W){1'b0}}, op_b};
            end
            X_WR_CTRL: begin
                x_addr  = CTRL_ADDR;
                x_wdata = 32'h1;
            end
            X_RD_OUT: begin
                x_addr  = OUT_ADDR;
                x_write = 1'b0;
                x_wdata = 32'h0;
            end
            default:   ;
        endcase
    end

    always_comb begin
        job_nxt = job;
        unique case (job)
            J_IDLE: if (accept) job_nxt = J_BUSY;
            J_BUSY: if ((x_done && xfer == X_RD_OUT) || x_abort) job_nxt = J_RESP;
            J_RESP: if (bus.rsp_ready) job_nxt = J_IDLE;
            default: job_nxt = J_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            job   <= J_IDLE;
            xfer  <= X_WR_A;
            op_a  <= '0;
            op_b  <= '0;
            res_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            job   <= job_nxt;
            rdy_q <= (job_nxt == J_IDLE);
            if (accept) begin
                op_a <= bus.req_a;
                op_b <= bus.req_b;
                xfer <= X_WR_A;
            end else if (job == J_BUSY && x_done && xfer != X_RD_OUT) begin
                xfer <= next_xfer(xfer);
            end
            if (job == J_BUSY && x_done && xfer == X_RD_OUT) res_q <= x_rdata[BCD_W-1:0];
            if (x_abort) res_q <= '0;
        end
    end

`ifdef APB_BCD_MASTER_TIMEOUT_EN
    logic err_q;

    always_ff @(posedge PCLK) begin
        if (PRESET)                                          err_q <= 1'b0;
        else if (x_abort)                                    err_q <= 1'b1;
        else if (job == J_BUSY && x_done && xfer == X_RD_OUT) err_q <= 1'b0;
    end

    assign bus.rsp_error = err_q;
`else
    assign bus.rsp_error = 1'b0;
`endif

    assign bus.req_ready  = rdy_q;
    assign bus.rsp_valid  = (job == J_RESP);
    assign bus.rsp_result = res_q;

    assign unused_rdata_hi = ^x_rdata[31:BCD_W];

    apb_xfer_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_xfer (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .start   (x_start),
        .addr    (x_addr),
        .write   (x_write),
        .wdata   (x_wdata),
        .done    (x_done),
        .abort   (x_abort),
        .rdata   (x_rdata),
        .psel    (bus.PSEL),
        .penable (bus.PENABLE),
        .pwrite  (bus.PWRITE),
        .paddr   (bus.PADDR),
        .pwdata  (bus.PWDATA),
        .prdata  (bus.PRDATA),
        .pready  (bus.PREADY)
    );

endmodule
